wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the register bank's single write port between NREQ writeback sources (ALU pipe, load unit, mul/div unit) using valid/ready handshakes.
- Drives the bank's write port from a registered output stage.
- Holds a 32-entry busy scoreboard for long-latency destinations and produces the decode-stage hazard stall.
- Sits between the writeback sources and reg_bank.

Parameters:
- NREQ, 3, number of writeback requesters (2..4); index 0 = ALU, 1 = load, 2 = mul/div.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk_sig  in  1  clock.
- rst_sig  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*AW  packed destination addresses; requester i at [i*AW +: AW].
- req_data  in  NREQ*DW  packed write data; requester i at [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant; transfer when valid&ready.
- wr_en  out  1  to bank write enable.
- rd_addr  out  AW  to bank write address.
- rd_data  out  DW  to bank write data.
- iss_valid  in  1  decode issuing a long-latency op (load or mul/div).
- iss_addr  in  AW  destination of that op.
- q_rs_en  in  1  decode reads rs.
- q_rs_addr  in  AW  rs address.
- q_rt_en  in  1  decode reads rt.
- q_rt_addr  in  AW  rt address.
- hazard_stall  out  1  decode must hold.
- busy_vec  out  32  scoreboard bits; bit 0 is always 0.

Behaviour:
- Reset (async):
  - wr_en=0, rd_addr=0, rd_data=0.
  - busy_vec=0.
  - round-robin pointer = 0.
  - req_ready=0 while rst_sig is high.
  - Requests in flight are dropped; sources must re-present them after reset.
- Arbitration:
  - Combinational each cycle; at most one req_ready bit is high, and only for a valid requester.
  - The write port accepts every cycle, so a sole valid requester is granted in the same cycle.
  - Requesters hold valid, addr and data stable until granted.
- Round-robin:
  - Search starts at the pointer.
  - After a grant to i, the pointer moves to (i+1) mod NREQ.
  - With no grant, the pointer is unchanged.
- Output stage latency:
  - At the edge after a grant: wr_en=1, rd_addr and rd_data take the granted values.
  - With no grant: wr_en=0 and addr/data hold their previous values.
  - A grant with address 0 completes the handshake but loads wr_en=0.
- Scoreboard set:
  - At the edge where iss_valid=1 and iss_addr!=0 and hazard_stall=0, busy[iss_addr] is set.
- Scoreboard clear:
  - At the edge where a grant loads the output stage, busy[granted addr] is cleared.
  - busy therefore falls in the same cycle wr_en rises; the bank's write bypass covers same-cycle readers.
- Simultaneous set and clear on the same address: set wins (new producer).
- hazard_stall is combinational, the OR of:
  - q_rs_en & busy[q_rs_addr];
  - q_rt_en & busy[q_rt_addr];
  - iss_valid & busy[iss_addr] (WAW guard; at most one outstanding producer per register).
- Address 0 never stalls.
- The ALU requester (0) is never scoreboarded; its hazards are resolved by the forwarding path.

Optional Feature:
- Macro: WB_RR_ARB_EN.
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority, highest index first (mul/div > load > ALU). This frees a blocked long-latency unit soonest.
  - The pointer register is removed.
  - All other behaviour is identical.

Decomposition:
- Shared package holds:
  - requester index constants REQ_ALU=0, REQ_LD=1, REQ_MD=2;
  - REG_ZERO=5'd0;
  - NUM_REGS=32.
- One natural sub-module: wb_rr_picker. Combinational: valid vector plus pointer in, one-hot grant out. Instantiated once; its fixed-priority form is selected by the macro.

Test Plan:
- Single request: reset, then req0 valid, addr 5, data 0x1234 → req_ready=001 the same cycle; next cycle wr_en=1, rd_addr=5, rd_data=0x1234.
- Contention (RR):
  - Setup: all three valid every cycle, pointer 0.
  - Grants: 001, 010, 100, 001 over four cycles.
  - wr_en stays high for four consecutive cycles.
  - With the macro undefined, the first grant is 100.
- Scoreboard stall:
  - Issue to r8 (busy[8]=1), then query rs=8 with q_rs_en=1 → hazard_stall=1.
  - Req2 then writes r8 → busy[8]=0 and hazard_stall=0 in the cycle wr_en=1.
- Same-edge set/clear on r9: grant clearing r9 plus a new issue to r9 → busy[9] remains 1.
- Zero register: grant with addr 0 → handshake completes, wr_en=0 next cycle; issue to r0 → busy_vec unchanged, no stall.
- Reset mid-operation: busy[3]=1 and req1 pending, assert rst_sig → immediately wr_en=0, busy_vec=0, req_ready=0; after release, the first grant follows pointer 0.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared constants for the writeback port arbiter.
package wb_port_arbiter_pkg;
  localparam int REQ_ALU = 0;
  localparam int REQ_LD = 1;
  localparam int REQ_MD = 2;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int NUM_REGS = 32;
endpackage

// File: rtl/wb_rr_picker.sv
// wb_rr_picker: one-hot grant from a valid vector; round-robin from ptr under
// WB_RR_ARB_EN, otherwise fixed priority with the highest index winning.
module wb_rr_picker #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         valid,
`ifdef WB_RR_ARB_EN
  input  logic [$clog2(NREQ)-1:0] ptr,
`endif
  output logic [NREQ-1:0]         gnt
);
`ifdef WB_RR_ARB_EN
  // Walk offsets from the far end so the requester nearest ptr is assigned last.
  always_comb begin
    gnt = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (valid[(int'(ptr) + k) % NREQ]) gnt = NREQ'(1) << ((int'(ptr) + k) % NREQ);
  end
`else
  always_comb begin
    gnt = '0;
    for (int k = 0; k < NREQ; k++)
      if (valid[k]) gnt = NREQ'(1) << k;
  end
`endif
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register bank write port among writeback sources and
// tracks busy destinations for decode hazards; WB_RR_ARB_EN selects round-robin.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic               clk_sig,
  input  logic               rst_sig,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               wr_en,
  output logic [AW-1:0]      rd_addr,
  output logic [DW-1:0]      rd_data,
  input  logic               iss_valid,
  input  logic [AW-1:0]      iss_addr,
  input  logic               q_rs_en,
  input  logic [AW-1:0]      q_rs_addr,
  input  logic               q_rt_en,
  input  logic [AW-1:0]      q_rt_addr,
  output logic               hazard_stall,
  output logic [31:0]        busy_vec
);
  logic [NREQ-1:0] valid_g, gnt;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_data;
  logic any_gnt, iss_set;
  logic [NUM_REGS-1:0] busy, set_mask, clr_mask;
  assign valid_g = rst_sig ? '0 : req_valid;
`ifdef WB_RR_ARB_EN
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] ptr, ptr_nxt;
  wb_rr_picker #(.NREQ(NREQ)) u_pick (.valid(valid_g), .ptr(ptr), .gnt(gnt));
  always_comb begin
    ptr_nxt = ptr;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) ptr_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
  end
  always_ff @(posedge clk_sig or posedge rst_sig)
    if (rst_sig) ptr <= '0;
    else ptr <= ptr_nxt;
`else
  wb_rr_picker #(.NREQ(NREQ)) u_pick (.valid(valid_g), .gnt(gnt));
`endif
  always_comb begin
    g_addr = '0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      g_addr = g_addr | (gnt[i] ? req_addr[i*AW +: AW] : '0);
      g_data = g_data | (gnt[i] ? req_data[i*DW +: DW] : '0);
    end
  end
  assign any_gnt = |gnt;
  assign req_ready = gnt;
  assign hazard_stall = (q_rs_en & busy[q_rs_addr]) | (q_rt_en & busy[q_rt_addr]) |
                        (iss_valid & busy[iss_addr]);
  assign iss_set = iss_valid && iss_addr != AW'(REG_ZERO) && !hazard_stall;
  assign set_mask = iss_set ? NUM_REGS'(1) << iss_addr : '0;
  assign clr_mask = any_gnt ? NUM_REGS'(1) << g_addr : '0;
  assign busy_vec = busy;
  // Set is applied after clear so a new producer wins over a same-edge writeback.
  always_ff @(posedge clk_sig or posedge rst_sig)
    if (rst_sig) begin
      busy <= '0;
      wr_en <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else begin
      busy <= ((busy & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
      wr_en <= any_gnt && g_addr != AW'(REG_ZERO);
      rd_addr <= any_gnt ? g_addr : rd_addr;
      rd_data <= any_gnt ? g_data : rd_data;
    end
endmodule
